fc_dllp_rx_decoder: RTL and testbench

//  Link-side receive decoder for flow-control DLLPs on VC0: classifies CRC-checked DLLPs, runs the
//  FC_INIT1 -> FC_INIT2 -> ACTIVE initialisation FSM, latches initial credits, forwards UpdateFC

---
 rtl/fc_dllp_rx_decoder.sv | 105 ++++++++++
 tb/tb_fc_dllp_rx_decoder.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/fc_dllp_rx_decoder.sv
// fc_dllp_rx_decoder: VC0 flow-control DLLP receive decoder with FC init FSM, credit latch and UpdateFC timeout
// Ports: clk/rst (async active-high); link_up_i forces IDLE when low; dllp_valid_i/dllp_i/crc_ok_i carry a
// CRC-checked DLLP body (byte0 in [31:24]); initfc_* give the initial credits of FC_TYPE with a 1-cycle
// initfc_valid_o pulse; updatefc_* give the latest tracked UpdateFC with a 1-cycle pulse; fc_init1_done_o and
// fc_init_done_o are FSM levels; fc_timeout_o is a sticky UpdateFC timeout; bad_dllp_cnt_o counts CRC failures.
module fc_dllp_rx_decoder #(
  parameter logic [1:0] FC_TYPE = 2'b00,
  parameter int TIMEOUT_CYCLES = 200000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        link_up_i,
  input  logic        dllp_valid_i,
  input  logic [31:0] dllp_i,
  input  logic        crc_ok_i,
  output logic [7:0]  initfc_hdr_credit_o,
  output logic [11:0] initfc_data_credit_o,
  output logic        initfc_valid_o,
  output logic [7:0]  updatefc_hdr_credit_o,
  output logic [11:0] updatefc_data_credit_o,
  output logic        updatefc_valid_o,
  output logic        fc_init1_done_o,
  output logic        fc_init_done_o,
  output logic        fc_timeout_o,
  output logic [7:0]  bad_dllp_cnt_o
);
  typedef enum logic [1:0] {IDLE, FC_INIT1, FC_INIT2, ACTIVE} state_t;
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  state_t state, state_nxt;
  logic [3:0] flags, flags_nxt;
  logic [CW-1:0] cnt;
  logic acc, is_init, is_upd, tracked, init_hit, upd_hit;
  logic [1:0] typ;
  logic [7:0] hdr;
  logic [11:0] data;
  logic unused;
  // byte0[7:6]: 01 InitFC1, 11 InitFC2, 10 UpdateFC; byte0[5:4] is the credit type (11 is not a credit type)
  assign acc = link_up_i & dllp_valid_i & crc_ok_i & (dllp_i[27:24] == 4'h0);
  assign typ = dllp_i[29:28];
  assign is_init = acc & (typ != 2'b11) & dllp_i[30];
  assign is_upd = acc & (typ != 2'b11) & dllp_i[31] & ~dllp_i[30];
  assign tracked = typ == FC_TYPE;
  assign hdr = {dllp_i[21:16], dllp_i[15:14]};
  assign data = {dllp_i[11:8], dllp_i[7:0]};
  assign unused = ^dllp_i[13:12];
  assign init_hit = is_init & (state == FC_INIT1);
  assign upd_hit = is_upd & tracked & (state == FC_INIT2 || state == ACTIVE);
  assign flags_nxt = init_hit ? (flags | (4'b0001 << typ)) : flags;
  assign fc_init1_done_o = state == FC_INIT2 || state == ACTIVE;
  assign fc_init_done_o = state == ACTIVE;
  always_comb begin
    state_nxt = state;
    if (!link_up_i) state_nxt = IDLE;
    else if (state == IDLE) state_nxt = FC_INIT1;
    else if (state == FC_INIT1 && &flags_nxt[2:0]) state_nxt = FC_INIT2;
    else if (state == FC_INIT2 && (is_init || is_upd) && dllp_i[31]) state_nxt = ACTIVE;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nxt;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      flags <= '0;
      cnt <= '0;
      initfc_hdr_credit_o <= '0;
      initfc_data_credit_o <= '0;
      initfc_valid_o <= 1'b0;
      updatefc_hdr_credit_o <= '0;
      updatefc_data_credit_o <= '0;
      updatefc_valid_o <= 1'b0;
      fc_timeout_o <= 1'b0;
      bad_dllp_cnt_o <= '0;
    end else begin
      bad_dllp_cnt_o <= (dllp_valid_i && !crc_ok_i && bad_dllp_cnt_o != 8'hFF) ? bad_dllp_cnt_o + 8'd1 : bad_dllp_cnt_o;
      initfc_valid_o <= 1'b0;
      updatefc_valid_o <= 1'b0;
      if (!link_up_i) begin
        flags <= '0;
        cnt <= '0;
        initfc_hdr_credit_o <= '0;
        initfc_data_credit_o <= '0;
        updatefc_hdr_credit_o <= '0;
        updatefc_data_credit_o <= '0;
        fc_timeout_o <= 1'b0;
      end else begin
        flags <= flags_nxt;
        if (init_hit && tracked && !flags[typ]) begin
          initfc_hdr_credit_o <= hdr;
          initfc_data_credit_o <= data;
          initfc_valid_o <= 1'b1;
        end
        if (upd_hit) begin
          updatefc_hdr_credit_o <= hdr;
          updatefc_data_credit_o <= data;
          updatefc_valid_o <= 1'b1;
        end
        // an UpdateFC on the threshold cycle clears the counter instead of timing out
        if (state != ACTIVE || upd_hit) cnt <= '0;
        else if (!fc_timeout_o) begin
          if (cnt == CW'(TIMEOUT_CYCLES - 1)) fc_timeout_o <= 1'b1;
          cnt <= cnt + CW'(1);
        end
      end
    end
endmodule

// File: tb/tb_fc_dllp_rx_decoder.sv
// tb_fc_dllp_rx_decoder: directed vector table plus hand sequences for fc_dllp_rx_decoder
module tb_fc_dllp_rx_decoder;
  localparam logic [31:0] P1 = 32'h40080200;
  localparam logic [31:0] P1B = 32'h40FFFFFF;
  localparam logic [31:0] NP1 = 32'h50044010;
  localparam logic [31:0] NP2 = 32'hD0044010;
  localparam logic [31:0] C1 = 32'hE0000000;
  localparam logic [31:0] U_P = 32'h80084201;
  localparam logic [31:0] U_P2 = 32'h8003C0AB;
  localparam logic [31:0] U_NP = 32'h90FFFFFF;
  localparam logic [31:0] ACK = 32'h00000000;
  localparam logic [31:0] U_VC1 = 32'h81FFFFFF;
  logic clk = 1'b0;
  logic rst, link_up, dllp_valid, crc_ok;
  logic [31:0] dllp;
  logic [7:0] initfc_hdr, updatefc_hdr, bad_cnt;
  logic [11:0] initfc_data, updatefc_data;
  logic initfc_valid, updatefc_valid, init1_done, init_done, timeout;
  logic [52:0] obs;
  int total = 0;
  int bad = 0;
  typedef struct {
    logic lu, v, c;
    logic [31:0] d;
    logic iv;
    logic [7:0] ih;
    logic [11:0] id;
    logic uv;
    logic [7:0] uh;
    logic [11:0] ud;
    logic d1, dn, to;
    logic [7:0] bc;
  } vec_t;
  vec_t tbl[15];
  fc_dllp_rx_decoder #(.FC_TYPE(2'b00), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk),
    .rst(rst),
    .link_up_i(link_up),
    .dllp_valid_i(dllp_valid),
    .dllp_i(dllp),
    .crc_ok_i(crc_ok),
    .initfc_hdr_credit_o(initfc_hdr),
    .initfc_data_credit_o(initfc_data),
    .initfc_valid_o(initfc_valid),
    .updatefc_hdr_credit_o(updatefc_hdr),
    .updatefc_data_credit_o(updatefc_data),
    .updatefc_valid_o(updatefc_valid),
    .fc_init1_done_o(init1_done),
    .fc_init_done_o(init_done),
    .fc_timeout_o(timeout),
    .bad_dllp_cnt_o(bad_cnt)
  );
  always #5 clk = ~clk;
  assign obs = {initfc_valid, initfc_hdr, initfc_data, updatefc_valid, updatefc_hdr, updatefc_data,
                init1_done, init_done, timeout, bad_cnt};
  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask
  task automatic step(input logic lu, input logic v, input logic c, input logic [31:0] d);
    link_up = lu;
    dllp_valid = v;
    crc_ok = c;
    dllp = d;
    @(posedge clk);
    #1;
  endtask
  initial begin
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 8'h00, 12'h000, 1'b0, 8'h00, 12'h000, 1'b0, 1'b0, 1'b0, 8'd0};
    tbl[1]  = '{1'b1, 1'b1, 1'b1, P1,    1'b1, 8'h20, 12'h200, 1'b0, 8'h00, 12'h000, 1'b0, 1'b0, 1'b0, 8'd0};
    tbl[2]  = '{1'b1, 1'b1, 1'b1, P1B,   1'b0, 8'h20, 12'h200, 1'b0, 8'h00, 12'h000, 1'b0, 1'b0, 1'b0, 8'd0};
    tbl[3]  = '{1'b1, 1'b1, 1'b0, NP1,   1'b0, 8'h20, 12'h200, 1'b0, 8'h00, 12'h000, 1'b0, 1'b0, 1'b0, 8'd1};
    tbl[4]  = '{1'b1, 1'b1, 1'b1, NP2,   1'b0, 8'h20, 12'h200, 1'b0, 8'h00, 12'h000, 1'b0, 1'b0, 1'b0, 8'd1};
    tbl[5]  = '{1'b1, 1'b1, 1'b1, U_P,   1'b0, 8'h20, 12'h200, 1'b0, 8'h00, 12'h000, 1'b0, 1'b0, 1'b0, 8'd1};
    tbl[6]  = '{1'b1, 1'b1, 1'b1, C1,    1'b0, 8'h20, 12'h200, 1'b0, 8'h00, 12'h000, 1'b1, 1'b0, 1'b0, 8'd1};
    tbl[7]  = '{1'b1, 1'b1, 1'b1, P1B,   1'b0, 8'h20, 12'h200, 1'b0, 8'h00, 12'h000, 1'b1, 1'b0, 1'b0, 8'd1};
    tbl[8]  = '{1'b1, 1'b1, 1'b1, U_P,   1'b0, 8'h20, 12'h200, 1'b1, 8'h21, 12'h201, 1'b1, 1'b1, 1'b0, 8'd1};
    tbl[9]  = '{1'b1, 1'b1, 1'b1, U_NP,  1'b0, 8'h20, 12'h200, 1'b0, 8'h21, 12'h201, 1'b1, 1'b1, 1'b0, 8'd1};
    tbl[10] = '{1'b1, 1'b1, 1'b1, ACK,   1'b0, 8'h20, 12'h200, 1'b0, 8'h21, 12'h201, 1'b1, 1'b1, 1'b0, 8'd1};
    tbl[11] = '{1'b1, 1'b1, 1'b1, U_VC1, 1'b0, 8'h20, 12'h200, 1'b0, 8'h21, 12'h201, 1'b1, 1'b1, 1'b0, 8'd1};
    tbl[12] = '{1'b1, 1'b1, 1'b1, U_P2,  1'b0, 8'h20, 12'h200, 1'b1, 8'h0F, 12'h0AB, 1'b1, 1'b1, 1'b0, 8'd1};
    tbl[13] = '{1'b1, 1'b1, 1'b1, P1,    1'b0, 8'h20, 12'h200, 1'b0, 8'h0F, 12'h0AB, 1'b1, 1'b1, 1'b0, 8'd1};
    tbl[14] = '{1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 8'h20, 12'h200, 1'b0, 8'h0F, 12'h0AB, 1'b1, 1'b1, 1'b0, 8'd1};
    rst = 1'b1;
    link_up = 1'b0;
    dllp_valid = 1'b0;
    crc_ok = 1'b0;
    dllp = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_state", 64'(obs), 64'h0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 15; i++) begin
      step(tbl[i].lu, tbl[i].v, tbl[i].c, tbl[i].d);
      chk($sformatf("vec%0d", i), 64'(obs), 64'({tbl[i].iv, tbl[i].ih, tbl[i].id, tbl[i].uv, tbl[i].uh, tbl[i].ud,
                                               tbl[i].d1, tbl[i].dn, tbl[i].to, tbl[i].bc}));
    end
    // two ACTIVE cycles elapsed since the last tracked UpdateFC; reach cycle 15, then UpdateFC on cycle 16
    repeat (13) step(1'b1, 1'b0, 1'b0, 32'h0);
    chk("to_before_16", 64'(timeout), 64'h0);
    step(1'b1, 1'b1, 1'b1, U_P);
    chk("to_upd_at_16", 64'(timeout), 64'h0);
    chk("upd_at_16_pulse", 64'({updatefc_valid, updatefc_hdr, updatefc_data}), 64'({1'b1, 8'h21, 12'h201}));
    repeat (15) step(1'b1, 1'b0, 1'b0, 32'h0);
    chk("to_cycle15", 64'(timeout), 64'h0);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    chk("to_cycle16", 64'(timeout), 64'h1);
    repeat (3) step(1'b1, 1'b0, 1'b0, 32'h0);
    chk("to_sticky", 64'({timeout, init_done}), 64'h3);
    step(1'b0, 1'b1, 1'b1, U_P);
    chk("link_down_clear", 64'(obs), 64'h1);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    repeat (2) step(1'b1, 1'b1, 1'b0, P1);
    chk("bad_cnt_3", 64'(bad_cnt), 64'd3);
    chk("bad_crc_ignored", 64'({initfc_valid, initfc_hdr, init1_done}), 64'h0);
    repeat (300) step(1'b1, 1'b1, 1'b0, P1);
    chk("bad_cnt_sat", 64'(bad_cnt), 64'd255);
    step(1'b1, 1'b1, 1'b1, P1);
    chk("init_p_again", 64'({initfc_valid, initfc_hdr, initfc_data}), 64'({1'b1, 8'h20, 12'h200}));
    step(1'b1, 1'b1, 1'b1, NP1);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    chk("drop_mid_init1", 64'({initfc_hdr, initfc_data, init1_done, bad_cnt}), 64'({8'h0, 12'h0, 1'b0, 8'd255}));
    step(1'b1, 1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b1, 1'b1, C1);
    chk("reup_cpl_only", 64'(init1_done), 64'h0);
    step(1'b1, 1'b1, 1'b1, P1);
    chk("reup_relatch", 64'({initfc_valid, initfc_hdr, init1_done}), 64'({1'b1, 8'h20, 1'b0}));
    step(1'b1, 1'b1, 1'b1, NP1);
    chk("reup_all_three", 64'(init1_done), 64'h1);
    step(1'b1, 1'b1, 1'b1, U_P);
    chk("reup_active", 64'({init_done, updatefc_valid}), 64'h3);
    #2;
    rst = 1'b1;
    #1;
    chk("async_reset", 64'(obs), 64'h0);
    @(negedge clk);
    rst = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
